// File: rtl/aes_stream_packer.sv
// aes_stream_packer: packs read-FIFO words into AES blocks, runs them through an AES core and unpacks results to the write FIFO (optional stall counter: AES_STREAM_STATS_EN)
module aes_stream_packer #(
  parameter int DATA_W        = 16,
  parameter int BLOCK_W       = 128,
  parameter int LVL_W         = 16,
  parameter int TOTAL_BLOCKS  = 49152,
  parameter int WR_HIGH_WATER = 256,
  parameter int START_DELAY   = 128,
  parameter int AES_TIMEOUT   = 1024
)(
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iSTART,
  input  logic [1:0]         iMODE,
  input  logic               iABORT,
  input  logic [LVL_W-1:0]   iRD_LEVEL,
  input  logic               iRD_BUSY,
  output logic               oRD,
  input  logic [DATA_W-1:0]  iRD_DATA,
  input  logic [LVL_W-1:0]   iWR_LEVEL,
  input  logic               iWR_BUSY,
  output logic               oWR,
  output logic [DATA_W-1:0]  oWR_DATA,
  output logic               oAES_LD,
  output logic               oAES_ENC,
  output logic [BLOCK_W-1:0] oAES_DATA,
  input  logic               iAES_DONE,
  input  logic [BLOCK_W-1:0] iAES_DATA,
  output logic [1:0]         oDONE,
  output logic [LVL_W+1:0]   oBLOCK_CNT,
  output logic [3:0]         oSTATE
`ifdef AES_STREAM_STATS_EN
  , output logic [31:0]      oSTALL_CNT
`endif
);
  localparam int WORDS = BLOCK_W / DATA_W;
  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = LVL_W + 2;
  typedef enum logic [3:0] {
    IDLE = 4'd0, START_WAIT = 4'd1, RD_WAIT = 4'd2, RD_REQ = 4'd3, RD_LAT = 4'd4,
    AES_LD = 4'd5, AES_WAIT = 4'd6, WR_WAIT = 4'd7, WR_PUSH = 4'd8, DONE = 4'd9
  } state_t;
  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [1:0]         done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        dly_q, dly_d;
  logic [31:0]        tmo_q, tmo_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [BLOCK_W-1:0] res_q, res_d;
  logic               start_ok, rd_ok, wr_ok, last_word, last_blk;
  assign start_ok  = iSTART && !iABORT && (iMODE == 2'b10 || iMODE == 2'b01) && (state_q == IDLE || state_q == DONE);
  assign rd_ok     = iRD_LEVEL >= LVL_W'(WORDS) && !iRD_BUSY;
  assign wr_ok     = iWR_LEVEL <= LVL_W'(WR_HIGH_WATER - WORDS) && !iWR_BUSY;
  assign last_word = idx_q == IDX_W'(WORDS - 1);
  assign last_blk  = cnt_q + 1'b1 == CNT_W'(TOTAL_BLOCKS);
  // next-state and datapath updates; abort overrides everything at the end
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dly_d   = dly_q;
    tmo_d   = tmo_q;
    blk_d   = blk_q;
    res_d   = res_q;
    case (state_q)
      IDLE, DONE: if (start_ok) begin
        state_d = START_WAIT;
        mode_d  = iMODE;
        done_d  = 2'b00;
        cnt_d   = '0;
        idx_d   = '0;
        dly_d   = '0;
      end
      START_WAIT: begin
        dly_d   = dly_q + 32'd1;
        state_d = dly_q == 32'(START_DELAY - 1) ? RD_WAIT : START_WAIT;
      end
      RD_WAIT: state_d = rd_ok ? RD_REQ : RD_WAIT;
      RD_REQ:  state_d = RD_LAT;
      RD_LAT: begin
        blk_d[idx_q*DATA_W +: DATA_W] = iRD_DATA;
        idx_d   = last_word ? '0 : idx_q + 1'b1;
        state_d = last_word ? AES_LD : RD_REQ;
      end
      AES_LD: begin
        // the load cycle itself is the first cycle of the timeout window
        tmo_d   = 32'd1;
        state_d = AES_WAIT;
      end
      AES_WAIT: begin
        tmo_d = tmo_q + 32'd1;
        if (iAES_DONE) begin
          res_d   = iAES_DATA;
          state_d = WR_WAIT;
        end else if (tmo_q + 32'd1 >= 32'(AES_TIMEOUT)) begin
          done_d  = 2'b11;
          state_d = DONE;
        end
      end
      WR_WAIT: state_d = wr_ok ? WR_PUSH : WR_WAIT;
      WR_PUSH: begin
        idx_d = last_word ? '0 : idx_q + 1'b1;
        if (last_word) begin
          cnt_d   = cnt_q + 1'b1;
          done_d  = last_blk ? mode_q : done_q;
          state_d = last_blk ? DONE : RD_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
    if (iABORT) begin
      state_d = IDLE;
      idx_d   = '0;
      done_d  = done_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
    end
  end
  // state and datapath registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      mode_q  <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      dly_q   <= '0;
      tmo_q   <= '0;
      blk_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dly_q   <= dly_d;
      tmo_q   <= tmo_d;
      blk_q   <= blk_d;
      res_q   <= res_d;
    end
  end
  assign oRD        = state_q == RD_REQ;
  assign oWR        = state_q == WR_PUSH;
  assign oWR_DATA   = res_q[idx_q*DATA_W +: DATA_W];
  assign oAES_LD    = state_q == AES_LD;
  assign oAES_ENC   = mode_q == 2'b10;
  assign oAES_DATA  = blk_q;
  assign oDONE      = done_q;
  assign oBLOCK_CNT = cnt_q;
  assign oSTATE     = state_q;
`ifdef AES_STREAM_STATS_EN
  logic [31:0] stall_q, stall_d;
  logic        stalled;
  assign stalled = (state_q == RD_WAIT && !rd_ok) || (state_q == WR_WAIT && !wr_ok);
  // saturating count of cycles blocked on FIFO levels or busy flags
  always_comb begin
    stall_d = start_ok ? 32'd0 : (stalled && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  end
  // stall counter register
  always_ff @(posedge iCLK) begin
    if (iRST) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign oSTALL_CNT = stall_q;
`endif
endmodule

// File: tb/tb_aes_stream_packer.sv
// tb_aes_stream_packer: directed checks of packing, flow control, timeout, abort and reset
module tb_aes_stream_packer;
  localparam int T_OUT = 20;
  localparam int S_DLY = 4;
  logic         clk = 1'b0;
  logic         iRST = 1'b1, iSTART = 1'b0, iABORT = 1'b0, iRD_BUSY = 1'b0, iWR_BUSY = 1'b0;
  logic [1:0]   iMODE = 2'b00;
  logic [15:0]  iRD_LEVEL = '0, iWR_LEVEL = '0, iRD_DATA, oWR_DATA;
  logic         oRD, oWR, oAES_LD, oAES_ENC, iAES_DONE;
  logic [127:0] oAES_DATA, iAES_DATA;
  logic [1:0]   oDONE;
  logic [17:0]  oBLOCK_CNT;
  logic [3:0]   oSTATE;
`ifdef AES_STREAM_STATS_EN
  logic [31:0]  oSTALL_CNT;
`endif
  aes_stream_packer #(.TOTAL_BLOCKS(2), .START_DELAY(S_DLY), .AES_TIMEOUT(T_OUT)) dut (
    .iCLK(clk), .iRST(iRST), .iSTART(iSTART), .iMODE(iMODE), .iABORT(iABORT),
    .iRD_LEVEL(iRD_LEVEL), .iRD_BUSY(iRD_BUSY), .oRD(oRD), .iRD_DATA(iRD_DATA),
    .iWR_LEVEL(iWR_LEVEL), .iWR_BUSY(iWR_BUSY), .oWR(oWR), .oWR_DATA(oWR_DATA),
    .oAES_LD(oAES_LD), .oAES_ENC(oAES_ENC), .oAES_DATA(oAES_DATA),
    .iAES_DONE(iAES_DONE), .iAES_DATA(iAES_DATA), .oDONE(oDONE),
    .oBLOCK_CNT(oBLOCK_CNT), .oSTATE(oSTATE)
`ifdef AES_STREAM_STATS_EN
    , .oSTALL_CNT(oSTALL_CNT)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [15:0] rd_mem [32];
  int rd_ptr = 0;
  logic [15:0] rd_word = '0;
  int acnt = 0;
  logic aes_en = 1'b1;
  always @(posedge clk) begin
    if (iRST) rd_ptr <= 0;
    else if (oRD) begin
      rd_word <= rd_mem[rd_ptr & 31];
      rd_ptr  <= rd_ptr + 1;
    end
  end
  assign iRD_DATA = rd_word;
  always @(posedge clk) begin
    if (oAES_LD) acnt <= 1;
    else if (acnt != 0) acnt <= (acnt == 12) ? 0 : acnt + 1;
  end
  assign iAES_DONE = aes_en && acnt == 12;
  assign iAES_DATA = oAES_DATA;
  int ncyc = 0, ld_cyc = -1, d3_cyc = -1;
  int rd_t[$], wr_t[$];
  logic [15:0] wr_q[$];
  logic [1:0] prev_done = 2'b00;
  always @(negedge clk) begin
    ncyc++;
    if (oRD) rd_t.push_back(ncyc);
    if (oWR) begin
      wr_q.push_back(oWR_DATA);
      wr_t.push_back(ncyc);
    end
    if (oAES_LD) ld_cyc = ncyc;
    if (oDONE == 2'b11 && prev_done != 2'b11) d3_cyc = ncyc;
    prev_done = oDONE;
  end
  function automatic int rdt(int i);
    return (i >= 0 && i < rd_t.size()) ? rd_t[i] : -1000;
  endfunction
  function automatic int wrt(int i);
    return (i >= 0 && i < wr_t.size()) ? wr_t[i] : -1000;
  endfunction
  function automatic logic [15:0] wrq(int i);
    return (i >= 0 && i < wr_q.size()) ? wr_q[i] : 16'hxxxx;
  endfunction
  task automatic tick(int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    iRST = 1'b1;
    iSTART = 1'b0;
    iABORT = 1'b0;
    tick(2);
    iRST = 1'b0;
  endtask
  task automatic pulse_start(input logic [1:0] m);
    iMODE = m;
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
  endtask
  task automatic pulse_abort();
    iABORT = 1'b1;
    tick();
    iABORT = 1'b0;
  endtask
  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && oDONE == 2'b00; i++) tick();
  endtask
  typedef struct {logic [1:0] mode; logic start; logic abort; logic [3:0] st; logic enc;} sv_t;
  typedef struct {logic [15:0] lvl; logic busy; logic fire;} lv_t;
  sv_t sv[6];
  lv_t lv[6];
  int rb, wb, n0;
  initial begin
    for (int i = 0; i < 32; i++) rd_mem[i] = 16'(16'h1357 * (i + 1) ^ (i << 11));
    sv[0] = '{2'b10, 1'b1, 1'b0, 4'd1, 1'b1};
    sv[1] = '{2'b01, 1'b1, 1'b0, 4'd1, 1'b0};
    sv[2] = '{2'b00, 1'b1, 1'b0, 4'd0, 1'b0};
    sv[3] = '{2'b11, 1'b1, 1'b0, 4'd0, 1'b0};
    sv[4] = '{2'b10, 1'b1, 1'b1, 4'd0, 1'b0};
    sv[5] = '{2'b10, 1'b0, 1'b0, 4'd0, 1'b0};
    lv[0] = '{16'd7,      1'b0, 1'b0};
    lv[1] = '{16'd8,      1'b0, 1'b1};
    lv[2] = '{16'd8,      1'b1, 1'b0};
    lv[3] = '{16'd0,      1'b0, 1'b0};
    lv[4] = '{16'hFFFF,   1'b0, 1'b1};
    lv[5] = '{16'd16,     1'b0, 1'b1};
    do_reset();
    chk("rst_state", oSTATE, 4'd0);
    chk("rst_rd", oRD, 1'b0);
    chk("rst_wr", oWR, 1'b0);
    chk("rst_wr_data", oWR_DATA, 16'd0);
    chk("rst_ld", oAES_LD, 1'b0);
    chk("rst_enc", oAES_ENC, 1'b0);
    chk("rst_aes_data", oAES_DATA, 128'd0);
    chk("rst_done", oDONE, 2'b00);
    chk("rst_cnt", oBLOCK_CNT, 18'd0);
    for (int i = 0; i < 6; i++) begin
      do_reset();
      iMODE = sv[i].mode;
      iSTART = sv[i].start;
      iABORT = sv[i].abort;
      tick();
      iSTART = 1'b0;
      iABORT = 1'b0;
      chk($sformatf("start_vec%0d_state", i), oSTATE, sv[i].st);
      chk($sformatf("start_vec%0d_enc", i), oAES_ENC, sv[i].enc);
    end
    for (int i = 0; i < 6; i++) begin
      do_reset();
      iRD_LEVEL = lv[i].lvl;
      iRD_BUSY = lv[i].busy;
      iWR_LEVEL = '0;
      rb = rd_t.size();
      pulse_start(2'b10);
      tick(12);
      chk($sformatf("lvl_vec%0d_rd", i), rd_t.size() > rb, lv[i].fire);
      iRD_BUSY = 1'b0;
    end
    do_reset();
    iRD_LEVEL = 16'd16;
    iWR_LEVEL = 16'd0;
    aes_en = 1'b1;
    rb = rd_t.size();
    wb = wr_q.size();
    pulse_start(2'b10);
    wait_done(1000);
    chk("t1_done", oDONE, 2'b10);
    chk("t1_cnt", oBLOCK_CNT, 18'd2);
    chk("t1_state", oSTATE, 4'd9);
    chk("t1_wr_count", wr_q.size() - wb, 16);
    for (int i = 0; i < 16; i++) chk($sformatf("t1_word%0d", i), wrq(wb + i), rd_mem[i]);
    chk("t1_rd_span", rdt(rb + 7) - rdt(rb), 14);
    chk("t1_wr_span", wrt(wb + 7) - wrt(wb), 7);
    do_reset();
    iRD_LEVEL = 16'd7;
    iWR_LEVEL = 16'd249;
    rb = rd_t.size();
    wb = wr_q.size();
    pulse_start(2'b10);
    tick(30);
    chk("t2_no_rd", rd_t.size() - rb, 0);
    chk("t2_rd_wait", oSTATE, 4'd2);
    iRD_LEVEL = 16'd8;
    for (int i = 0; i < 200 && oSTATE != 4'd7; i++) tick();
    chk("t2_rd_count", rd_t.size() - rb, 8);
    for (int k = 1; k < 8; k++) chk($sformatf("t2_rd_gap%0d", k), rdt(rb + k) - rdt(rb + k - 1), 2);
    tick(30);
    chk("t3_no_wr", wr_q.size() - wb, 0);
    chk("t3_wr_wait", oSTATE, 4'd7);
    iRD_LEVEL = 16'd0;
    iWR_LEVEL = 16'd248;
    tick(20);
    chk("t3_wr_count", wr_q.size() - wb, 8);
    chk("t3_wr_span", wrt(wb + 7) - wrt(wb), 7);
    chk("t3_word0", wrq(wb), rd_mem[0]);
    chk("t3_word7", wrq(wb + 7), rd_mem[7]);
    chk("t3_cnt", oBLOCK_CNT, 18'd1);
    chk("t3_back_rd_wait", oSTATE, 4'd2);
    do_reset();
    aes_en = 1'b0;
    iRD_LEVEL = 16'd16;
    iWR_LEVEL = 16'd0;
    pulse_start(2'b10);
    for (int i = 0; i < 300 && oDONE != 2'b11; i++) tick();
    chk("t4_done", oDONE, 2'b11);
    chk("t4_latency", d3_cyc - ld_cyc, T_OUT);
    chk("t4_state", oSTATE, 4'd9);
    chk("t4_cnt", oBLOCK_CNT, 18'd0);
    pulse_abort();
    chk("t4_abort_state", oSTATE, 4'd0);
    chk("t4_abort_keeps_done", oDONE, 2'b11);
    pulse_start(2'b01);
    chk("t4_restart_state", oSTATE, 4'd1);
    chk("t4_restart_done", oDONE, 2'b00);
    chk("t4_restart_enc", oAES_ENC, 1'b0);
    pulse_abort();
    aes_en = 1'b1;
    do_reset();
    rb = rd_t.size();
    pulse_start(2'b10);
    for (int i = 0; i < 100 && rd_t.size() - rb < 3; i++) tick();
    pulse_abort();
    chk("t5_abort_state", oSTATE, 4'd0);
    chk("t5_abort_done", oDONE, 2'b00);
    n0 = rd_t.size();
    tick(10);
    chk("t5_abort_no_rd", rd_t.size() - n0, 0);
    wb = wr_q.size();
    pulse_start(2'b10);
    for (int i = 0; i < 300 && wr_q.size() - wb < 3; i++) tick();
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    chk("t5_rst_state", oSTATE, 4'd0);
    chk("t5_rst_wr", oWR, 1'b0);
    chk("t5_rst_done", oDONE, 2'b00);
    chk("t5_rst_cnt", oBLOCK_CNT, 18'd0);
    chk("t5_rst_aes_data", oAES_DATA, 128'd0);
    chk("t5_rst_enc", oAES_ENC, 1'b0);
    n0 = wr_q.size();
    tick(10);
    chk("t5_rst_no_wr", wr_q.size() - n0, 0);
    wb = wr_q.size();
    pulse_start(2'b01);
    chk("t5_dec_enc", oAES_ENC, 1'b0);
    wait_done(1000);
    chk("t5_done", oDONE, 2'b01);
    chk("t5_cnt", oBLOCK_CNT, 18'd2);
    chk("t5_wr_count", wr_q.size() - wb, 16);
    for (int i = 0; i < 16; i++) chk($sformatf("t5_word%0d", i), wrq(wb + i), rd_mem[i]);
    do_reset();
    pulse_start(2'b00);
    tick(S_DLY + 4);
    chk("t6_bad_mode_idle", oSTATE, 4'd0);
`ifdef AES_STREAM_STATS_EN
    do_reset();
    iRD_LEVEL = 16'd0;
    pulse_start(2'b10);
    for (int i = 0; i < 50 && oSTATE != 4'd2; i++) tick();
    chk("t6_stall_start", oSTALL_CNT, 32'd0);
    tick(5);
    chk("t6_stall_cnt", oSTALL_CNT, 32'd5);
    pulse_start(2'b10);
    chk("t6_stall_ignored_start", oSTALL_CNT, 32'd6);
    pulse_abort();
    pulse_start(2'b10);
    chk("t6_stall_clear", oSTALL_CNT, 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
endmodule
